traffic_monitor: RTL and testbench

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

---
 rtl/traffic_monitor_if.sv | 24 ++
 rtl/traffic_monitor.sv | 166 ++++++++++++++++
 tb/tb_traffic_monitor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/traffic_monitor_if.sv
// Observed light codes plus monitor status outputs, bundled for traffic_monitor.
// Pure wiring, no latency of its own.
// No backpressure: the monitor only observes; the master side drives lights and clr.
interface traffic_monitor_if;
  logic [1:0] l1;
  logic [1:0] l2;
  logic [1:0] l3;
  logic       clr;
  logic [2:0] phase;
  logic       locked;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] cycle_cnt;

  modport master (
    output l1, l2, l3, clr,
    input  phase, locked, err, err_code, cycle_cnt
  );

  modport slave (
    input  l1, l2, l3, clr,
    output phase, locked, err, err_code, cycle_cnt
  );
endinterface

// File: rtl/traffic_monitor.sv
// Checks a 3-light signal against the legal phase sequence; sticky first-error capture.
// Latency: lights sampled directly each edge, all outputs registered (1 cycle).
// No backpressure; dwell limits only when TRAFFIC_MON_DWELL_CHECK_EN is defined.
module traffic_monitor #(
  parameter int GREEN_CYC  = 9,
  parameter int YELLOW_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  traffic_monitor_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_P1   = 4'd1,
    S_P2   = 4'd2,
    S_P3   = 4'd3,
    S_P4   = 4'd4,
    S_P5   = 4'd5,
    S_P6   = 4'd6,
    S_ERR  = 4'd7,
    S_HUNT = 4'd8
  } state_t;

  localparam logic [2:0] PAT_ILL = 3'd7;
  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PAT   = 3'd1;
  localparam logic [2:0] E_SEQ   = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_LONG  = 3'd4;

  state_t     st, nxt;
  logic [2:0] pat;
  logic [2:0] last_pat;
  logic [2:0] cur;
  logic [2:0] seq_next;
  logic [2:0] cause;
  logic       wrap;
  logic       short_dwell;
  logic       long_dwell;

  logic [2:0] phase_q, phase_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;
  logic [7:0] cnt_q, cnt_d;

  // Pattern currently held by the state (only meaningful in IDLE..P6) and its legal successor.
  assign cur      = st[2:0];
  assign seq_next = (cur == 3'd6) ? 3'd1 : cur + 3'd1;

  // Decode the three light codes into phase pattern 0..6, or 7 for anything illegal.
  always_comb begin
    pat = PAT_ILL;
    case ({bus.l1, bus.l2, bus.l3})
      6'b10_10_10: pat = 3'd0;
      6'b00_10_10: pat = 3'd1;
      6'b01_10_10: pat = 3'd2;
      6'b10_00_10: pat = 3'd3;
      6'b10_01_10: pat = 3'd4;
      6'b10_10_00: pat = 3'd5;
      6'b10_10_01: pat = 3'd6;
      default:     pat = PAT_ILL;
    endcase
  end

`ifdef TRAFFIC_MON_DWELL_CHECK_EN
  localparam logic [3:0] G_LIM = 4'(GREEN_CYC);
  localparam logic [3:0] Y_LIM = 4'(YELLOW_CYC);

  logic [3:0] dwell_q, dwell_d;
  logic [3:0] lim;

  // Odd phases are green, even phases yellow; IDLE has no limit at all.
  always_comb begin
    lim         = cur[0] ? G_LIM : Y_LIM;
    short_dwell = (cur != 3'd0) && (dwell_q < lim);
    long_dwell  = (cur != 3'd0) && (dwell_q == lim);
  end

  // Dwell restarts at 1 on entering any phase, counts up while it holds, otherwise parks at 0.
  always_comb begin
    dwell_d = 4'd0;
    if (nxt != st && nxt <= S_P6)
      dwell_d = 4'd1;
    else if (nxt == st && st <= S_P6)
      dwell_d = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dwell_q <= 4'd0;
    else      dwell_q <= dwell_d;
  end
`else
  assign short_dwell = 1'b0;
  assign long_dwell  = 1'b0;
`endif

  // State and output registers; last_pat lets HUNT see when the pattern changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= S_IDLE;
      last_pat   <= 3'd0;
      phase_q    <= 3'd0;
      locked_q   <= 1'b1;
      err_q      <= 1'b0;
      err_code_q <= E_NONE;
      cnt_q      <= 8'd0;
    end else begin
      st         <= nxt;
      last_pat   <= pat;
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next state: checks ordered so the highest-priority cause is the one reported.
  always_comb begin
    nxt   = st;
    cause = E_NONE;
    wrap  = 1'b0;
    case (st)
      S_ERR: begin
        if (pat == PAT_ILL) cause = E_PAT;
        else if (bus.clr)   nxt = S_HUNT;
      end
      S_HUNT: begin
        if (pat == PAT_ILL) cause = E_PAT;
        else if (pat != last_pat && pat != 3'd0) nxt = state_t'({1'b0, pat});
      end
      default: begin
        if (pat == PAT_ILL) cause = E_PAT;
        else if (pat != cur) begin
          if (pat != seq_next) cause = E_SEQ;
          else if (short_dwell) cause = E_SHORT;
          else begin
            nxt  = state_t'({1'b0, pat});
            wrap = (cur == 3'd6);
          end
        end else if (long_dwell) cause = E_LONG;
      end
    endcase
    if (cause != E_NONE) nxt = S_ERR;
  end

  // Output values for the coming edge; an already-latched error code is never replaced.
  always_comb begin
    phase_d    = (nxt == S_HUNT) ? pat : nxt[2:0];
    locked_d   = (nxt != S_ERR) && (nxt != S_HUNT);
    err_d      = (nxt == S_ERR);
    err_code_d = E_NONE;
    if (nxt == S_ERR) err_code_d = (st == S_ERR) ? err_code_q : cause;
    cnt_d      = cnt_q + {7'd0, wrap};
  end

  assign bus.phase     = phase_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed scoreboard bench for traffic_monitor: stimulus pushes expectations,
// a separate monitor compares them at their due time slot.
module tb_traffic_monitor;
  logic clk = 1'b0;
  logic rst;

  traffic_monitor_if bus();

  traffic_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [5:0] RRR = 6'b10_10_10;
  localparam logic [5:0] GRR = 6'b00_10_10;
  localparam logic [5:0] YRR = 6'b01_10_10;
  localparam logic [5:0] RGR = 6'b10_00_10;
  localparam logic [5:0] RYR = 6'b10_01_10;
  localparam logic [5:0] RRG = 6'b10_10_00;
  localparam logic [5:0] RRY = 6'b10_10_01;
  localparam logic [5:0] GGR = 6'b00_00_10;

  typedef struct {
    int         slot;
    logic [2:0] ph;
    logic       lk;
    logic       e;
    logic [2:0] code;
    logic [7:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  logic [7:0] exp_cnt;
  bit    after_p6;
  string tag;

  function automatic logic [5:0] pat_of(int ph);
    logic [5:0] v;
    case (ph)
      1: v = GRR;
      2: v = YRR;
      3: v = RGR;
      4: v = RYR;
      5: v = RRG;
      6: v = RRY;
      default: v = RRR;
    endcase
    return v;
  endfunction

  task automatic push(int slot, logic [2:0] ph, logic lk, logic e, logic [2:0] code, logic [7:0] cnt);
    exp_t x;
    x.slot = slot; x.ph = ph; x.lk = lk; x.e = e; x.code = code; x.cnt = cnt;
    exp_q.push_back(x);
    name_q.push_back(tag);
  endtask

  // Drive one pattern for the next edge and expect the registered result after it.
  task automatic step(logic [5:0] v, logic c, logic [2:0] ph, logic lk, logic e, logic [2:0] code, logic [7:0] cnt);
    @(posedge clk);
    #1;
    {bus.l1, bus.l2, bus.l3} = v;
    bus.clr = c;
    push(2 * (cyc + 1), ph, lk, e, code, cnt);
  endtask

  task automatic ok(logic [5:0] v, logic [2:0] ph);
    step(v, 1'b0, ph, 1'b1, 1'b0, 3'd0, exp_cnt);
  endtask

  // Assert reset between edges and expect reset values before the next edge arrives.
  task automatic do_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    {bus.l1, bus.l2, bus.l3} = RRR;
    bus.clr = 1'b0;
    exp_cnt = 8'd0;
    after_p6 = 1'b0;
    push(2 * cyc + 1, 3'd0, 1'b1, 1'b0, 3'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic nominal_cycle();
    for (int ph = 1; ph <= 6; ph++) begin
      for (int i = 0; i < ((ph % 2 == 1) ? 9 : 4); i++) begin
        if (ph == 1 && i == 0 && after_p6) exp_cnt = exp_cnt + 8'd1;
        ok(pat_of(ph), 3'(ph));
      end
    end
    after_p6 = 1'b1;
  endtask

  task automatic check_slot(int s);
    exp_t  x;
    string n;
    while (exp_q.size() > 0 && exp_q[0].slot <= s) begin
      x = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (bus.phase !== x.ph || bus.locked !== x.lk || bus.err !== x.e ||
          bus.err_code !== x.code || bus.cycle_cnt !== x.cnt) begin
        bad++;
        $display("FAIL %s @cyc %0d: got phase=%0d locked=%0b err=%0b code=%0d cnt=%0d, want phase=%0d locked=%0b err=%0b code=%0d cnt=%0d",
                 n, cyc, bus.phase, bus.locked, bus.err, bus.err_code, bus.cycle_cnt,
                 x.ph, x.lk, x.e, x.code, x.cnt);
      end
    end
  endtask

  // Monitor: even slots at the falling edge, odd slots shortly after it (async reset checks).
  initial begin
    forever begin
      @(negedge clk);
      check_slot(2 * cyc);
      #3;
      check_slot(2 * cyc + 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    {bus.l1, bus.l2, bus.l3} = RRR;
    bus.clr = 1'b0;
    exp_cnt = 8'd0;
    after_p6 = 1'b0;

    tag = "reset";      do_reset();
    tag = "idle";       repeat (5) ok(RRR, 3'd0);
    tag = "nominal";    repeat (2) nominal_cycle();

    tag = "cnt2";
    exp_cnt = exp_cnt + 8'd1;
    repeat (9) ok(GRR, 3'd1);
    repeat (4) ok(YRR, 3'd2);
    repeat (2) ok(RGR, 3'd3);
    tag = "illegal_p3"; step(GGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd1, 8'd2);
    tag = "clr_vs_err"; step(GGR, 1'b1, 3'd7, 1'b0, 1'b1, 3'd1, 8'd2);
    tag = "err_hold";   step(RGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd1, 8'd2);
    tag = "clr_hunt";   step(RGR, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 8'd2);
    tag = "hunt_stay";  step(RGR, 1'b0, 3'd3, 1'b0, 1'b0, 3'd0, 8'd2);
    tag = "relock";     step(RYR, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 8'd2);
    repeat (3) ok(RYR, 3'd4);
    tag = "rst_mid_p4"; do_reset();
    tag = "idle_judge"; step(RGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd2, 8'd0);

    tag = "seq_skip";   do_reset();
    repeat (9) ok(GRR, 3'd1);
    step(RGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd2, 8'd0);

    tag = "to_idle";    do_reset();
    repeat (9) ok(GRR, 3'd1);
    repeat (4) ok(YRR, 3'd2);
    step(RRR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd2, 8'd0);
    tag = "hunt_idle";  step(RRR, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0);
    tag = "hunt_ill";   step(GGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd1, 8'd0);

`ifdef TRAFFIC_MON_DWELL_CHECK_EN
    tag = "short_green";  do_reset();
    repeat (8) ok(GRR, 3'd1);
    step(YRR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd3, 8'd0);
    tag = "short_yellow"; do_reset();
    repeat (9) ok(GRR, 3'd1);
    repeat (3) ok(YRR, 3'd2);
    step(RGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd3, 8'd0);
    tag = "prio_seq";     do_reset();
    repeat (8) ok(GRR, 3'd1);
    step(RGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd2, 8'd0);
    tag = "long_green";   do_reset();
    repeat (9) ok(GRR, 3'd1);
    step(GRR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd4, 8'd0);
    tag = "sticky_code";  step(GGR, 1'b0, 3'd7, 1'b0, 1'b1, 3'd4, 8'd0);
`else
    tag = "no_dwell";   do_reset();
    repeat (20) ok(GRR, 3'd1);
    repeat (20) ok(YRR, 3'd2);
    ok(RGR, 3'd3);
`endif

    tag = "wrap";       do_reset();
    repeat (256) nominal_cycle();
    tag = "wrap_zero";  step(GRR, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 8'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
